// File: rtl/onehot_enc_8_3_seq_pkg.sv
// Shared constants and types for the sequential 8-to-3 one-hot/priority encoder.
// The vector is emitted one set bit per beat, MSB first.
package onehot_enc_8_3_seq_pkg;

   localparam int unsigned VEC_W  = 8;
   localparam int unsigned CODE_W = 3;

   typedef logic [VEC_W-1:0]  vec_t;
   typedef logic [CODE_W-1:0] code_t;

   // FSM state encoding, kept as plain constants for legacy tools.
   typedef logic [0:0] state_t;
   localparam state_t IDLE = 1'b0;
   localparam state_t EMIT = 1'b1;

   // Code 0 maps to bit 7, code 7 maps to bit 0.
   function automatic vec_t code_to_mask(input code_t code);
      vec_t msb;
      msb = vec_t'(1) << (VEC_W - 1);
      return msb >> code;
   endfunction

endpackage

// File: rtl/onehot_enc_8_3_seq_prio_enc.sv
// Combinational MSB-first priority encoder: code of the highest set bit, plus
// flags for an all-zero vector and for exactly one bit set.
module prio_enc_8_3
   import onehot_enc_8_3_seq_pkg::*;
(
   input  logic [VEC_W-1:0]  vec,
   output logic [CODE_W-1:0] code,
   output logic              zero,
   output logic              one
);

   always_comb begin
      code = '0;
      // Ascending scan so the most significant set bit wins.
      for (int i = 0; i < VEC_W; i++) begin
         if (vec[i]) begin
            code = code_t'(VEC_W - 1 - i);
         end
      end
   end

   always_comb begin
      zero = ~|vec;
      // Clearing the lowest set bit leaves nothing only when one bit was set.
      one  = !zero && ((vec & (vec - vec_t'(1))) == '0);
   end

endmodule

// File: rtl/onehot_enc_8_3_seq.sv
// Captures an 8-bit request vector and emits the code of each set bit, MSB
// first, one beat per out_valid/out_ready handshake.
module onehot_enc_8_3_seq
   import onehot_enc_8_3_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [VEC_W-1:0]  in_vec,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CODE_W-1:0] out_code,
   output logic              out_last,
   output logic              out_none
);

   state_t state_q, state_d;
   vec_t   pend_q, pend_d;

   code_t  enc_code;
   logic   enc_zero;
   logic   enc_one;

   prio_enc_8_3 u_prio_enc (
      .vec  (pend_q),
      .code (enc_code),
      .zero (enc_zero),
      .one  (enc_one)
   );

   // Outputs come only from registered state, never from in_vec.
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == EMIT);
      out_code  = out_valid ? enc_code : '0;
      out_none  = out_valid & enc_zero;
      out_last  = out_valid & (enc_one | enc_zero);
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               pend_d  = in_vec;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               pend_d = pend_q & ~code_to_mask(enc_code);
               if (out_last) begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            pend_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
      end
   end

endmodule

// File: tb/tb_onehot_enc_8_3_seq.sv
// Directed bench for onehot_enc_8_3_seq: table of vectors with hand-computed
// beat sequences plus hand-written backpressure, reset and back-to-back cases.
module tb_onehot_enc_8_3_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_vec;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_code;
   logic       out_last;
   logic       out_none;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   onehot_enc_8_3_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_vec    (in_vec),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_code  (out_code),
      .out_last  (out_last),
      .out_none  (out_none)
   );

   typedef struct {
      logic [7:0]      vec;
      int              n;
      logic            none;
      logic [7:0][2:0] codes;
   } vec_rec_t;

   function automatic vec_rec_t mk(input logic [7:0] v, input int n, input logic none,
                                   input logic [2:0] c0, input logic [2:0] c1,
                                   input logic [2:0] c2, input logic [2:0] c3,
                                   input logic [2:0] c4, input logic [2:0] c5,
                                   input logic [2:0] c6, input logic [2:0] c7);
      vec_rec_t r;
      r.vec      = v;
      r.n        = n;
      r.none     = none;
      r.codes[0] = c0;
      r.codes[1] = c1;
      r.codes[2] = c2;
      r.codes[3] = c3;
      r.codes[4] = c4;
      r.codes[5] = c5;
      r.codes[6] = c6;
      r.codes[7] = c7;
      return r;
   endfunction

   task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " in_ready"}, 8'(in_ready), 8'd1);
      check({tag, " out_valid"}, 8'(out_valid), 8'd0);
   endtask

   task automatic check_beat(input string tag, input logic [2:0] code, input logic last,
                             input logic none);
      check({tag, " out_valid"}, 8'(out_valid), 8'd1);
      check({tag, " in_ready"}, 8'(in_ready), 8'd0);
      check({tag, " out_code"}, 8'(out_code), 8'(code));
      check({tag, " out_last"}, 8'(out_last), 8'(last));
      check({tag, " out_none"}, 8'(out_none), 8'(none));
   endtask

   // Accept one vector, then expect n beats with out_ready held high.
   task automatic run_vec(input string tag, input logic [7:0] v, input int n,
                          input logic none, input logic [7:0][2:0] codes);
      in_valid = 1'b1;
      in_vec   = v;
      check({tag, " accept in_ready"}, 8'(in_ready), 8'd1);
      tick();
      in_valid = 1'b0;
      in_vec   = 8'h00;
      for (int b = 0; b < n; b++) begin
         check_beat($sformatf("%s beat%0d", tag, b), codes[b], (b == n - 1), none);
         tick();
      end
      check_idle({tag, " done"});
   endtask

   vec_rec_t tbl[6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = mk(8'h80, 1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
      tbl[1] = mk(8'hA1, 3, 1'b0, 3'd0, 3'd2, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
      tbl[2] = mk(8'h00, 1, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
      tbl[3] = mk(8'hFF, 8, 1'b0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7);
      tbl[4] = mk(8'h01, 1, 1'b0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
      tbl[5] = mk(8'h18, 2, 1'b0, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_vec    = 8'h00;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_idle("reset");
      check("reset out_code", 8'(out_code), 8'd0);
      check("reset out_last", 8'(out_last), 8'd0);
      check("reset out_none", 8'(out_none), 8'd0);

      for (int i = 0; i < 6; i++) begin
         run_vec($sformatf("tbl%0d", i), tbl[i].vec, tbl[i].n, tbl[i].none, tbl[i].codes);
      end

      // Backpressure: code 1 held for 3 stalled cycles, in_valid pulses ignored.
      in_valid = 1'b1;
      in_vec   = 8'h42;
      tick();
      in_vec    = 8'hFF;
      out_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         in_valid = s[0] ? 1'b0 : 1'b1;
         check_beat($sformatf("stall%0d", s), 3'd1, 1'b0, 1'b0);
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_beat("bp beat0", 3'd1, 1'b0, 1'b0);
      tick();
      check_beat("bp beat1", 3'd6, 1'b1, 1'b0);
      tick();
      check_idle("bp done");
      tick();
      check_idle("bp no capture");

      // Reset mid-EMIT after code 3 handshakes discards the rest of 8'hFF.
      in_valid = 1'b1;
      in_vec   = 8'hFF;
      tick();
      in_valid = 1'b0;
      for (int b = 0; b < 4; b++) begin
         check_beat($sformatf("rstmid beat%0d", b), 3'(b), 1'b0, 1'b0);
         tick();
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle("rstmid after");
      check("rstmid out_code", 8'(out_code), 8'd0);
      tick();
      check_idle("rstmid quiet");
      run_vec("post rst", 8'h01, 1, 1'b0, tbl[4].codes);

      // Back-to-back: second vector offered continuously, captured only once idle.
      in_valid = 1'b1;
      in_vec   = 8'hC0;
      tick();
      in_vec = 8'h05;
      check_beat("b2b a0", 3'd0, 1'b0, 1'b0);
      tick();
      check_beat("b2b a1", 3'd1, 1'b1, 1'b0);
      tick();
      check_idle("b2b gap");
      tick();
      in_valid = 1'b0;
      in_vec   = 8'h00;
      check_beat("b2b b0", 3'd5, 1'b0, 1'b0);
      tick();
      check_beat("b2b b1", 3'd7, 1'b1, 1'b0);
      tick();
      check_idle("b2b done");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/onehot_enc_8_3_seq.md
ONEHOT_ENC_8_3_SEQ -- requirements
Module: onehot_enc_8_3_seq

Interface
REQ-001 Parameters: none; vector width fixed at 8, code width fixed at 3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream offers in_vec this cycle.
REQ-005 in_vec  input  8  request vector; bit 7 maps to code 0, bit 0 maps to code 7.
REQ-006 in_ready  output  1  block can accept a vector this cycle.
REQ-007 out_valid  output  1  out_code/out_last/out_none valid this cycle.
REQ-008 out_ready  input  1  downstream accepts current beat.
REQ-009 out_code  output  3  encoded index of highest-priority pending bit (code = 7 - bit position).
REQ-010 out_last  output  1  current beat is the final beat for the captured vector.
REQ-011 out_none  output  1  captured vector was all-zero; beat carries no valid index.

Function
REQ-012 States: IDLE, EMIT.
REQ-013 IDLE: in_ready = 1, out_valid = 0.
REQ-014 IDLE and in_valid = 1: capture in_vec into the pending register; go to EMIT next cycle.
REQ-015 EMIT: in_ready = 0, out_valid = 1; in_valid ignored.
REQ-016 Latency: vector accepted in cycle N; first beat valid in cycle N+1.
REQ-017 out_code = code of the most-significant set bit of the pending register (bit 7 first, down to bit 0).
REQ-018 out_last = 1 when exactly one pending bit remains.
REQ-019 out_none = 1, out_code = 3'b000, out_last = 1 when the pending register is all-zero (single beat).
REQ-020 Handshake in EMIT (out_valid & out_ready): clear the emitted bit; if out_last = 1, go to IDLE next cycle, else stay in EMIT.
REQ-021 With out_ready held high, one code per cycle; a vector with k set bits (k >= 1) takes k EMIT cycles.
REQ-022 Backpressure: while out_valid = 1 and out_ready = 0, out_code, out_last and out_none hold stable and the pending register is unchanged.
REQ-023 After the last beat handshake, in_ready = 1 in the following cycle; no same-cycle re-accept.
REQ-024 in_vec = 8'hFF produces codes 0,1,...,7 in order, out_last only on code 7.
REQ-025 Outputs depend only on registered state and pending register (no in_vec -> out_code combinational path).

Reset
REQ-026 rst = 1 at a rising edge: state = IDLE, pending register = 8'h00 on that edge.
REQ-027 Reset values after the edge: in_ready = 1, out_valid = 0, out_code = 3'b000, out_last = 0, out_none = 0.
REQ-028 Reset asserted mid-EMIT discards remaining pending bits; no further beats are emitted for that vector.
REQ-029 rst has priority over any handshake in the same cycle.

Structure
REQ-030 Shared package holds: state enum {IDLE, EMIT}, constants VEC_W = 8, CODE_W = 3.
REQ-031 One sub-module, prio_enc_8_3: combinational MSB-first priority encoder giving code, zero flag and a one-remaining flag from an 8-bit vector.
REQ-032 Top module holds the FSM, the pending register and the handshake logic only.

Verification
REQ-033 Reset, then in_vec = 8'b1000_0000 with out_ready = 1 -> one beat: code 0, last = 1, none = 0; in_ready = 1 two cycles after accept.
REQ-034 in_vec = 8'b1010_0001, out_ready = 1 -> beats code 0, 2, 7 on consecutive cycles, last only on 7.
REQ-035 in_vec = 8'h00 -> one beat: none = 1, code = 0, last = 1.
REQ-036 in_vec = 8'b0100_0010, out_ready low 3 cycles after out_valid -> code 1 held stable 3 cycles; then codes 1, 6 complete; in_valid pulses during EMIT not captured.
REQ-037 in_vec = 8'hFF, rst pulsed after code 3 handshakes -> next cycle out_valid = 0, in_ready = 1; new in_vec = 8'b0000_0001 yields single beat code 7, last = 1.
REQ-038 Back-to-back: two vectors offered continuously -> second captured only in the cycle after first vector's last beat handshake; no beat lost or duplicated.
